// File: rtl/qadd_pipe_if.sv
// Handshake bus for qadd_pipe: input beat channel, result channel and stats controls.
// "slave" is the adder's view; "master" is the producer/consumer side.
interface qadd_pipe_if #(
    parameter int N     = 20,
    parameter int LANES = 4,
    parameter int CNT_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_mode;
    logic                 in_last;
    logic [LANES*N-1:0]   in_a;
    logic [LANES*N-1:0]   in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*N-1:0]   out_c;
    logic [LANES-1:0]     out_sat;
    logic [CNT_W-1:0]     sat_count;
    logic                 clr_stats;

    modport slave (
        input  in_valid, in_mode, in_last, in_a, in_b, out_ready, clr_stats,
        output in_ready, out_valid, out_c, out_sat, sat_count
    );

    modport master (
        output in_valid, in_mode, in_last, in_a, in_b, out_ready, clr_stats,
        input  in_ready, out_valid, out_c, out_sat, sat_count
    );
endinterface

// File: rtl/qadd_pipe.sv
// Two-stage multi-lane saturating fixed-point adder/accumulator with valid/ready flow
// control, per-lane saturation flags and a clamping saturation event counter.
module qadd_pipe #(
    parameter int N     = 20,
    parameter int Q     = 11,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    qadd_pipe_if.slave  bus
);
    localparam logic [1:0]   M_ADD  = 2'b00;
    localparam logic [1:0]   M_SUB  = 2'b01;
    localparam logic [1:0]   M_ACC  = 2'b10;
    localparam logic [1:0]   M_HALF = 2'b11;
    localparam logic [N-1:0] MAXV   = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINV   = {1'b1, {(N-1){1'b0}}};

    if (Q >= N) begin : g_bad_q
        $error("qadd_pipe: Q must be smaller than N");
    end

    logic                 w_adv;
    logic                 w_emit;
    logic [LANES*N-1:0]   w_res;
    logic [LANES-1:0]     w_ovf;
    logic [LANES-1:0]     w_sat;
    logic [CNT_W:0]       w_pop;
    logic [CNT_W:0]       w_sum;

    logic                 r_s1_valid;
    logic [1:0]           r_s1_mode;
    logic                 r_s1_last;
    logic [LANES*N-1:0]   r_s1_a;
    logic [LANES*N-1:0]   r_s1_b;
    logic [LANES*N-1:0]   r_acc;
    logic [LANES-1:0]     r_accsat;
    logic                 r_out_valid;
    logic [LANES*N-1:0]   r_out_c;
    logic [LANES-1:0]     r_out_sat;
    logic [CNT_W-1:0]     r_cnt;

    assign w_adv         = !r_out_valid || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_out_valid;
    assign bus.out_c     = r_out_c;
    assign bus.out_sat   = r_out_sat;
    assign bus.sat_count = r_cnt;

    // Accumulate beats without in_last only update acc and never reach the output.
    assign w_emit = r_s1_valid && ((r_s1_mode != M_ACC) || r_s1_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= '0;
            r_s1_last  <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_adv) begin
            r_s1_valid <= bus.in_valid;
            r_s1_mode  <= bus.in_mode;
            r_s1_last  <= bus.in_last;
            r_s1_a     <= bus.in_a;
            r_s1_b     <= bus.in_b;
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [N-1:0] w_x;
        logic [N-1:0] w_y;
        logic [N:0]   w_ext;

        assign w_x   = (r_s1_mode == M_ACC) ? r_acc[gi*N +: N]  : r_s1_a[gi*N +: N];
        assign w_y   = (r_s1_mode == M_ACC) ? r_s1_a[gi*N +: N] : r_s1_b[gi*N +: N];
        assign w_ext = (r_s1_mode == M_SUB) ? ({w_x[N-1], w_x} - {w_y[N-1], w_y})
                                            : ({w_x[N-1], w_x} + {w_y[N-1], w_y});

        // The halved sum always fits in N bits, so it is exempt from saturation.
        assign w_ovf[gi] = (r_s1_mode != M_HALF) && (w_ext[N] != w_ext[N-1]);
        assign w_res[gi*N +: N] = (r_s1_mode == M_HALF) ? w_ext[N:1] :
                                  w_ovf[gi]             ? (w_ext[N] ? MINV : MAXV) :
                                                          w_ext[N-1:0];
        assign w_sat[gi] = (r_s1_mode == M_ACC) ? (r_accsat[gi] | w_ovf[gi]) : w_ovf[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_accsat <= '0;
        end else if (w_adv && r_s1_valid && (r_s1_mode == M_ACC)) begin
            if (r_s1_last) begin
                r_acc    <= '0;
                r_accsat <= '0;
            end else begin
                r_acc    <= w_res;
                r_accsat <= r_accsat | w_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_c     <= '0;
            r_out_sat   <= '0;
        end else if (w_adv) begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_c   <= w_res;
                r_out_sat <= w_sat;
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop = w_pop + (CNT_W+1)'(r_out_sat[i]);
        end
    end

    assign w_sum = {1'b0, r_cnt} + w_pop;

    // Clear takes priority over a same-cycle increment; the counter sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (bus.clr_stats) begin
            r_cnt <= '0;
        end else if (r_out_valid && bus.out_ready) begin
            r_cnt <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_qadd_pipe.sv
// Scoreboard bench for qadd_pipe: a behavioural integer model predicts each emitted
// beat and the saturation counter; a negedge monitor compares against the DUT.
module tb_qadd_pipe;
    localparam int N     = 20;
    localparam int Q     = 11;
    localparam int LANES = 4;
    localparam int CNT_W = 8;
    localparam int W     = LANES * N;
    localparam longint MAXI = (longint'(1) << (N - 1)) - 1;
    localparam longint MINI = -(longint'(1) << (N - 1));
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qadd_pipe_if #(.N(N), .LANES(LANES), .CNT_W(CNT_W)) bus ();

    qadd_pipe #(.N(N), .Q(Q), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int ntx    = 0;
    int rdy_mode = 0;
    int rdy_idx  = 0;

    logic [W-1:0]     q_c[$];
    logic [LANES-1:0] q_sat[$];
    logic [N-1:0]     m_acc[LANES];
    logic [LANES-1:0] m_accsat;
    int               m_cnt;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] lane(input int i, input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        r[i*N +: N] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] all_lanes(input logic [N-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*N +: N] = v;
        return r;
    endfunction

    function automatic logic [N-1:0] rnd_val();
        logic [31:0] t;
        t = $urandom();
        case ($urandom_range(0, 4))
            0:       return {1'b0, {(N-1){1'b1}}};
            1:       return {1'b1, {(N-1){1'b0}}};
            2:       return '0;
            default: return t[N-1:0];
        endcase
    endfunction

    // Integer reference: widen, compute exactly, then clamp to the N-bit range.
    task automatic model(input logic [1:0] mode, input logic last,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0]     c;
        logic [LANES-1:0] s;
        logic [N-1:0]     la, lb;
        longint           x, y, r;
        bit               ov;
        c = '0;
        s = '0;
        for (int i = 0; i < LANES; i++) begin
            la = a[i*N +: N];
            lb = b[i*N +: N];
            x  = longint'($signed(la));
            y  = longint'($signed(lb));
            case (mode)
                2'b00:   r = x + y;
                2'b01:   r = x - y;
                2'b10:   r = longint'($signed(m_acc[i])) + x;
                default: r = (x + y) >>> 1;
            endcase
            ov = (mode != 2'b11) && ((r > MAXI) || (r < MINI));
            if (r > MAXI) r = MAXI;
            else if (r < MINI) r = MINI;
            c[i*N +: N] = r[N-1:0];
            if (mode == 2'b10) begin
                if (last) begin
                    s[i]        = m_accsat[i] | ov;
                    m_acc[i]    = '0;
                    m_accsat[i] = 1'b0;
                end else begin
                    m_acc[i]    = r[N-1:0];
                    m_accsat[i] = m_accsat[i] | ov;
                end
            end else begin
                s[i] = ov;
            end
        end
        if ((mode != 2'b10) || last) begin
            q_c.push_back(c);
            q_sat.push_back(s);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [1:0] mode, input logic last,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_last  = last;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!acc && n <= 100) begin
            @(negedge clk);
            acc = (bus.in_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        if (acc) model(mode, last, a, b);
        else check("send_timeout", 128'(0), 128'(1));
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_c.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 128'(q_c.size()), 128'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        rdy_idx++;
        case (rdy_mode)
            1:       bus.out_ready = ((rdy_idx % 4) == 0) || ((rdy_idx % 4) == 3);
            2:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'b1;
        endcase
    end

    always @(negedge rst_n) begin
        q_c.delete();
        q_sat.delete();
        for (int i = 0; i < LANES; i++) m_acc[i] = '0;
        m_accsat = '0;
        m_cnt    = 0;
    end

    logic             prev_stall = 1'b0;
    logic [W-1:0]     prev_c;
    logic [LANES-1:0] prev_sat;
    logic [W-1:0]     exp_c;
    logic [LANES-1:0] exp_s;

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", 128'(bus.in_ready), 128'(!bus.out_valid || bus.out_ready));
            check("sat_count", 128'(bus.sat_count), 128'(m_cnt));
            if (prev_stall) begin
                check("stall_valid", 128'(bus.out_valid), 128'(1));
                check("stall_c", 128'(bus.out_c), 128'(prev_c));
                check("stall_sat", 128'(bus.out_sat), 128'(prev_sat));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q_c.size() == 0) begin
                    check("unexpected_out", 128'(bus.out_c), 128'(0));
                    check("unexpected_beat", 128'(1), 128'(0));
                end else begin
                    exp_c = q_c.pop_front();
                    exp_s = q_sat.pop_front();
                    ntx++;
                    $display("txn %0d c=%h sat=%b exp_c=%h exp_sat=%b cnt=%0d",
                             ntx, bus.out_c, bus.out_sat, exp_c, exp_s, bus.sat_count);
                    check("out_c", 128'(bus.out_c), 128'(exp_c));
                    check("out_sat", 128'(bus.out_sat), 128'(exp_s));
                end
            end
            // Predict the counter for the upcoming edge.
            if (bus.clr_stats) m_cnt = 0;
            else if (bus.out_valid && bus.out_ready) begin
                m_cnt = m_cnt + $countones(bus.out_sat);
                if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_c     = bus.out_c;
            prev_sat   = bus.out_sat;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] md;
        logic       lst;
        logic [W-1:0] ra, rb;
        bus.in_valid  = 1'b0;
        bus.in_mode   = '0;
        bus.in_last   = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        bus.clr_stats = 1'b0;
        for (int i = 0; i < LANES; i++) m_acc[i] = '0;
        m_accsat = '0;
        m_cnt    = 0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_out_c", 128'(bus.out_c), 128'(0));
        check("rst_out_sat", 128'(bus.out_sat), 128'(0));
        check("rst_sat_count", 128'(bus.sat_count), 128'(0));
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1;

        // Latency: driven now, visible after the second rising edge.
        send(2'b00, 1'b0, lane(0, 20'h00800), lane(0, 20'h00400));
        idle();
        @(negedge clk);
        check("latency_early", 128'(bus.out_valid), 128'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("latency_valid", 128'(bus.out_valid), 128'(1));
        check("add_lane0", 128'(bus.out_c[N-1:0]), 128'(20'h00C00));
        @(posedge clk);
        #1;

        send(2'b00, 1'b0, lane(1, 20'h7FFFF), lane(1, 20'h00001));
        send(2'b01, 1'b0, lane(2, 20'h00000), lane(2, 20'h80000));
        send(2'b11, 1'b0, lane(3, 20'h7FFFF), lane(3, 20'h7FFFF));
        send(2'b11, 1'b0, lane(3, 20'hFFFFF), lane(3, 20'h00000));
        idle();
        drain();
        check("count_after_ovf", 128'(bus.sat_count), 128'(2));

        for (int k = 0; k < 4; k++)
            send(2'b10, (k == 3), all_lanes(20'h40000), '0);
        send(2'b10, 1'b0, all_lanes(20'h00100), '0);
        send(2'b00, 1'b0, lane(0, 20'h00003), lane(0, 20'h00004));
        send(2'b10, 1'b1, all_lanes(20'h00200), all_lanes(20'h12345));
        idle();
        drain();
        check("count_after_acc", 128'(bus.sat_count), 128'(6));

        rdy_mode = 1;
        for (int k = 0; k < 6; k++)
            send(2'(k % 2), 1'b0, all_lanes(20'(k * 20'h1111)), all_lanes(20'h00777));
        for (int k = 0; k < 30; k++) begin
            md = 2'($urandom_range(0, 3));
            lst = (md == 2'b10) && ($urandom_range(0, 2) == 0);
            for (int i = 0; i < LANES; i++) begin
                ra[i*N +: N] = rnd_val();
                rb[i*N +: N] = rnd_val();
            end
            send(md, lst, ra, rb);
        end
        send(2'b10, 1'b1, '0, '0);
        idle();
        drain();

        rdy_mode = 0;
        for (int k = 0; k < 70; k++)
            send(2'b00, 1'b0, all_lanes(20'h7FFFF), all_lanes(20'h7FFFF));
        idle();
        drain();
        check("count_clamped", 128'(bus.sat_count), 128'(CNT_MAX));

        send(2'b00, 1'b0, all_lanes(20'h7FFFF), all_lanes(20'h7FFFF));
        idle();
        @(posedge clk);
        #1;
        bus.clr_stats = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_stats = 1'b0;
        @(negedge clk);
        check("clr_beats_inc", 128'(bus.sat_count), 128'(0));
        @(posedge clk);
        #1;

        send(2'b00, 1'b0, all_lanes(20'h80000), all_lanes(20'h80000));
        idle();
        drain();
        check("count_before_rst", 128'(bus.sat_count), 128'(4));

        // Reset in the middle of an accumulate packet with a stalled result.
        rdy_mode = 2;
        send(2'b10, 1'b0, all_lanes(20'h00100), '0);
        send(2'b00, 1'b0, lane(0, 20'h00005), lane(0, 20'h00006));
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("stalled_valid", 128'(bus.out_valid), 128'(1));
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 128'(bus.out_valid), 128'(0));
        check("async_rst_c", 128'(bus.out_c), 128'(0));
        check("async_rst_sat", 128'(bus.out_sat), 128'(0));
        check("async_rst_count", 128'(bus.sat_count), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send(2'b10, 1'b0, all_lanes(20'h00100), '0);
        send(2'b10, 1'b1, all_lanes(20'h00200), '0);
        idle();
        @(negedge clk);
        @(negedge clk);
        check("post_rst_acc", 128'(bus.out_c), 128'(all_lanes(20'h00300)));
        @(posedge clk);
        #1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
